// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// the datapath mux / ALU-op selector values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_ALU   = 4'd7,
    EXEC_I   = 4'd8,
    WB_IMM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style main controller: Moore FSM driving the datapath
// control lines, with the opcode captured in DECODE for the rest of the instruction.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  stateT      state, nextState;
  logic [5:0] opReg;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH;
      opReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opReg <= instr_op_i;
    end
  end

  // NOTE: every combinationally written signal gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:    if (mem_ready_i) nextState = DECODE;
      DECODE: begin
        case (instr_op_i)
          OP_RTYPE:       nextState = EXEC_R;
          OP_LW, OP_SW:   nextState = MEM_ADDR;
          OP_ADDI, OP_SLTI: nextState = EXEC_I;
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_J:           nextState = JUMP;
          default:        nextState = FETCH;
        endcase
      end
      MEM_ADDR: nextState = (opReg == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready_i) nextState = WB_MEM;
      WB_MEM:   nextState = FETCH;
      MEM_WR:   if (mem_ready_i) nextState = FETCH;
      EXEC_R:   nextState = WB_ALU;
      WB_ALU:   nextState = FETCH;
      EXEC_I:   nextState = WB_IMM;
      WB_IMM:   nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    i_or_d_o        = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    pc_src_o        = PCSRC_ALU;
    illegal_o       = 1'b0;
    // Reset masks every control line so no memory request escapes mid-reset.
    if (!rst_i) begin
      unique case (state)
        FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE: begin
          alu_src_b_o = SRCB_IMMSH;
          case (instr_op_i)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI,
            OP_BEQ, OP_BNE, OP_J: illegal_o = 1'b0;
            default:              illegal_o = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        MEM_WR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        WB_ALU: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = (opReg == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        WB_IMM: reg_write_o = 1'b1;
        BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_src_o        = PCSRC_ALUOUT;
          branch_ne_o     = (opReg == OP_BNE);
        end
        JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: the stimulus pushes the expected control
// vector for each cycle into a scoreboard; a monitor pops and compares.
module tb_mc_control_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, ir_write_o;
  logic       mem_read_o, mem_write_o, i_or_d_o, reg_write_o, reg_dst_o;
  logic       mem_to_reg_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;

  mc_control_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .ir_write_o(ir_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .i_or_d_o(i_or_d_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] st;
    logic       pcW, pcWC, bne, irW, mRd, mWr, iOrD, rW, rDst, m2r, srcA;
    logic [1:0] srcB, aluOp, pcSrc;
    logic       ill;
  } ctrlT;

  typedef struct {
    ctrlT  exp;
    string tag;
  } scoreT;

  scoreT q[$];
  int    nChecks = 0;
  int    nFails  = 0;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                         S_WBMEM = 4'd4, S_MWR = 4'd5, S_EXR = 4'd6, S_WBALU = 4'd7,
                         S_EXI = 4'd8, S_WBIMM = 4'd9, S_BR = 4'd10, S_JMP = 4'd11;

  // Reference control values for one cycle, written from the state table.
  function automatic ctrlT expFor(logic [3:0] st, logic [5:0] op, logic rdy, logic rst);
    ctrlT e;
    e    = '0;
    e.st = st;
    if (rst) return e;
    case (st)
      S_FETCH:  begin e.mRd = 1; e.srcB = 2'b01; e.pcW = rdy; e.irW = rdy; end
      S_DECODE: begin
        e.srcB = 2'b11;
        e.ill  = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B});
      end
      S_MADDR:  begin e.srcA = 1; e.srcB = 2'b10; end
      S_MRD:    begin e.mRd = 1; e.iOrD = 1; end
      S_WBMEM:  begin e.rW = 1; e.m2r = 1; end
      S_MWR:    begin e.mWr = 1; e.iOrD = 1; end
      S_EXR:    begin e.srcA = 1; e.aluOp = 2'b10; end
      S_WBALU:  begin e.rW = 1; e.rDst = 1; end
      S_EXI:    begin e.srcA = 1; e.srcB = 2'b10; e.aluOp = (op == 6'h0A) ? 2'b11 : 2'b00; end
      S_WBIMM:  e.rW = 1;
      S_BR:     begin e.srcA = 1; e.aluOp = 2'b01; e.pcWC = 1; e.pcSrc = 2'b01; e.bne = (op == 6'h05); end
      S_JMP:    begin e.pcW = 1; e.pcSrc = 2'b10; end
      default:  ;
    endcase
    return e;
  endfunction

  // Drive one cycle: drvOp goes to the DUT, insOp is the instruction actually in flight.
  task automatic cyc(input logic [5:0] drvOp, input logic [5:0] insOp, input logic rdy,
                     input logic rst, input logic [3:0] st, input string tag);
    scoreT s;
    instr_op_i  = drvOp;
    mem_ready_i = rdy;
    rst_i       = rst;
    s.exp = expFor(st, insOp, rdy, rst);
    s.tag = tag;
    q.push_back(s);
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetchDecode(input logic [5:0] op, input string tag);
    cyc(6'h3F, op, 1'b1, 1'b0, S_FETCH, {tag, "_fetch"});
    cyc(op, op, 1'b1, 1'b0, S_DECODE, {tag, "_decode"});
  endtask

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      scoreT s;
      ctrlT  act;
      s   = q.pop_front();
      act = '{state_o, pc_write_o, pc_write_cond_o, branch_ne_o, ir_write_o, mem_read_o,
              mem_write_o, i_or_d_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
              alu_src_b_o, alu_op_o, pc_src_o, illegal_o};
      nChecks++;
      if (act !== s.exp) begin
        nFails++;
        $display("FAIL %s: actual state=%0d ctrl=%h, required state=%0d ctrl=%h",
                 s.tag, act.st, act, s.exp.st, s.exp);
      end
      if (mem_read_o && mem_write_o) begin
        nFails++;
        $display("FAIL %s: mem_read_o and mem_write_o both 1, required at most one", s.tag);
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    instr_op_i  = 6'h00;
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc(6'h00, 6'h00, 1'b1, 1'b1, S_FETCH, "reset_hold");
    cyc(6'h00, 6'h00, 1'b0, 1'b1, S_FETCH, "reset_hold_nordy");

    // lw, memory always ready; opcode changed mid-instruction must be ignored
    fetchDecode(6'h23, "lw");
    cyc(6'h2B, 6'h23, 1'b1, 1'b0, S_MADDR, "lw_maddr");
    cyc(6'h2B, 6'h23, 1'b1, 1'b0, S_MRD,   "lw_mrd");
    cyc(6'h2B, 6'h23, 1'b1, 1'b0, S_WBMEM, "lw_wbmem");

    // sw with three wait cycles, preceded by a fetch wait
    cyc(6'h2B, 6'h2B, 1'b0, 1'b0, S_FETCH, "sw_fetch_wait");
    fetchDecode(6'h2B, "sw");
    cyc(6'h2B, 6'h2B, 1'b1, 1'b0, S_MADDR, "sw_maddr");
    for (int i = 0; i < 3; i++) cyc(6'h2B, 6'h2B, 1'b0, 1'b0, S_MWR, "sw_mwr_wait");
    cyc(6'h2B, 6'h2B, 1'b1, 1'b0, S_MWR, "sw_mwr_done");

    fetchDecode(6'h05, "bne");
    cyc(6'h04, 6'h05, 1'b1, 1'b0, S_BR, "bne_branch");

    fetchDecode(6'h04, "beq");
    cyc(6'h05, 6'h04, 1'b1, 1'b0, S_BR, "beq_branch");

    fetchDecode(6'h3F, "illegal");

    fetchDecode(6'h0A, "slti");
    cyc(6'h08, 6'h0A, 1'b1, 1'b0, S_EXI,   "slti_exec");
    cyc(6'h08, 6'h0A, 1'b1, 1'b0, S_WBIMM, "slti_wb");

    fetchDecode(6'h08, "addi");
    cyc(6'h0A, 6'h08, 1'b1, 1'b0, S_EXI,   "addi_exec");
    cyc(6'h0A, 6'h08, 1'b1, 1'b0, S_WBIMM, "addi_wb");

    fetchDecode(6'h00, "rtype");
    cyc(6'h00, 6'h00, 1'b1, 1'b0, S_EXR,   "rtype_exec");
    cyc(6'h00, 6'h00, 1'b1, 1'b0, S_WBALU, "rtype_wb");

    fetchDecode(6'h02, "j");
    cyc(6'h02, 6'h02, 1'b1, 1'b0, S_JMP, "j_jump");

    // reset asserted during a MEM_RD wait
    fetchDecode(6'h23, "lwrst");
    cyc(6'h23, 6'h23, 1'b1, 1'b0, S_MADDR, "lwrst_maddr");
    cyc(6'h23, 6'h23, 1'b0, 1'b0, S_MRD,   "lwrst_mrd_wait");
    cyc(6'h23, 6'h23, 1'b0, 1'b1, S_MRD,   "lwrst_rst_in_mrd");
    cyc(6'h23, 6'h23, 1'b0, 1'b1, S_FETCH, "lwrst_rst_held");
    cyc(6'h23, 6'h23, 1'b0, 1'b0, S_FETCH, "lwrst_first_fetch");
    fetchDecode(6'h2B, "post_rst_sw");
    cyc(6'h2B, 6'h2B, 1'b1, 1'b0, S_MADDR, "post_rst_sw_maddr");
    cyc(6'h2B, 6'h2B, 1'b1, 1'b0, S_MWR,   "post_rst_sw_mwr");
    cyc(6'h00, 6'h00, 1'b0, 1'b0, S_FETCH, "final_fetch");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk_i);
    if (q.size() > 0) begin
      nFails++;
      $display("FAIL drain: %0d scoreboard entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port instr_op_i, input, 6 bits: opcode field of the instruction register, valid from DECODE onward.
REQ-004 The block SHALL have the port mem_ready_i, input, 1 bit: memory completes the current read or write access this cycle.
REQ-005 The block SHALL have the port pc_write_o, output, 1 bit: unconditional PC load.
REQ-006 The block SHALL have the port pc_write_cond_o, output, 1 bit: PC load qualified by ALU zero, external gating.
REQ-007 The block SHALL have the port branch_ne_o, output, 1 bit: invert the zero qualification for bne.
REQ-008 The block SHALL have the ports ir_write_o, mem_read_o, mem_write_o and i_or_d_o, output, 1 bit each: instruction-register load, memory read request, memory write request, address select (0 = PC, 1 = ALUOut).
REQ-009 The block SHALL have the ports reg_write_o, reg_dst_o and mem_to_reg_o, output, 1 bit each: register-file write, destination select (1 = rd), write-data select (1 = MDR).
REQ-010 The block SHALL have the port alu_src_a_o, output, 1 bit (0 = PC, 1 = rs), and the port alu_src_b_o, output, 2 bits (00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm << 2).
REQ-011 The block SHALL have the port alu_op_o, output, 2 bits: 00 = add, 01 = sub, 10 = funct-decoded, 11 = set-less-than.
REQ-012 The block SHALL have the port pc_src_o, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-013 The block SHALL have the port illegal_o, output, 1 bit: one-cycle pulse on an unrecognised opcode.
REQ-014 The block SHALL have the port state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-015 The FSM states SHALL be FETCH(0), DECODE(1), MEM_ADDR(2), MEM_RD(3), WB_MEM(4), MEM_WR(5), EXEC_R(6), WB_ALU(7), EXEC_I(8), WB_IMM(9), BRANCH(10), JUMP(11).
REQ-016 All outputs SHALL be Moore outputs of the state and default to 0 in every state unless listed.
REQ-017 FETCH SHALL assert mem_read_o=1 with i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01 and alu_op_o=00, and SHALL remain in FETCH while mem_ready_i=0.
REQ-018 ir_write_o and pc_write_o SHALL be asserted combinationally only in the FETCH cycle where mem_ready_i=1; next state is DECODE.
REQ-019 DECODE SHALL assert alu_src_a_o=0, alu_src_b_o=11 and alu_op_o=00, and then SHALL dispatch on opcode: 0x00 -> EXEC_R; 0x23 or 0x2B -> MEM_ADDR; 0x08 or 0x0A -> EXEC_I; 0x04 or 0x05 -> BRANCH; 0x02 -> JUMP; any other opcode -> FETCH with illegal_o=1 for that cycle.
REQ-020 MEM_ADDR SHALL assert alu_src_a_o=1 and alu_src_b_o=10 with alu_op_o=00, and then SHALL go to MEM_RD for 0x23 and to MEM_WR for 0x2B.
REQ-021 MEM_RD SHALL assert mem_read_o=1 and i_or_d_o=1, and SHALL hold until mem_ready_i=1, then go to WB_MEM.
REQ-022 WB_MEM SHALL assert reg_write_o=1, mem_to_reg_o=1 and reg_dst_o=0, and then SHALL go to FETCH.
REQ-023 MEM_WR SHALL assert mem_write_o=1 and i_or_d_o=1, and SHALL hold until mem_ready_i=1, then go to FETCH.
REQ-024 EXEC_R SHALL assert alu_src_a_o=1, alu_src_b_o=00 and alu_op_o=10, and then SHALL go to WB_ALU; WB_ALU SHALL assert reg_write_o=1 and reg_dst_o=1, and then SHALL go to FETCH.
REQ-025 EXEC_I SHALL assert alu_src_a_o=1 and alu_src_b_o=10, with alu_op_o=00 for 0x08 and 11 for 0x0A, and then SHALL go to WB_IMM; WB_IMM SHALL assert reg_write_o=1 and reg_dst_o=0, and then SHALL go to FETCH.
REQ-026 BRANCH SHALL assert alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_write_cond_o=1 and pc_src_o=01, with branch_ne_o=1 for 0x05, and then SHALL go to FETCH.
REQ-027 JUMP SHALL assert pc_write_o=1 and pc_src_o=10, and then SHALL go to FETCH.
REQ-028 The block SHALL hold the opcode internally from DECODE until the return to FETCH, so that instr_op_i changes mid-instruction are ignored.
REQ-029 Cycles per instruction SHALL be: R-type/addi/slti 4, lw 5, sw 4, beq/bne 3, j 3, each excluding memory wait cycles; an illegal opcode costs 2.
REQ-030 mem_read_o and mem_write_o SHALL never be asserted in the same cycle.

Reset
REQ-031 With rst_i=1 at a clock edge, the state SHALL become FETCH and the latched opcode SHALL become 0, regardless of the current state, including during a memory wait.
REQ-032 While rst_i=1, all outputs except state_o=0 SHALL be forced to 0, including mem_read_o.
REQ-033 The first fetch SHALL begin in the first cycle after rst_i is deasserted.

Structure
REQ-034 The state encodings, opcode constants and the alu_op_o, alu_src_b_o and pc_src_o encodings SHALL reside in a shared package, mc_ctrl_pkg.
REQ-035 The block SHALL be one module with no sub-modules; the next-state logic and output decode SHALL be separate combinational processes.

Verification
REQ-036 The bench SHALL drive reset, then lw (0x23) with mem_ready_i=1 always, and SHALL check the state sequence 0,1,2,3,4,0 and reg_write_o=1 with mem_to_reg_o=1 only in state 4.
REQ-037 The bench SHALL drive sw (0x2B) with mem_ready_i held low for 3 cycles in MEM_WR, and SHALL check mem_write_o=1 for 4 cycles, then FETCH, with reg_write_o never asserted.
REQ-038 The bench SHALL drive bne (0x05), and SHALL check in BRANCH: pc_write_cond_o=1, branch_ne_o=1, alu_op_o=01 and pc_src_o=01, followed by FETCH.
REQ-039 The bench SHALL drive opcode 0x3F, and SHALL check illegal_o=1 for exactly one cycle in DECODE, followed by FETCH.
REQ-040 The bench SHALL assert rst_i during a MEM_RD wait, and SHALL check that in the next cycle state_o=0 and all outputs are 0 while reset is held.
REQ-041 The bench SHALL drive slti (0x0A), and SHALL check alu_op_o=11 in EXEC_I and reg_dst_o=0 in WB_IMM.
